eth_rx_frame_queue: RTL and testbench

ETH_RX_FRAME_QUEUE -- requirements
Module: eth_rx_frame_queue

---
 rtl/eth_rx_frame_queue.sv | 241 ++++++++++++++++++++++++
 tb/tb_eth_rx_frame_queue.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_frame_queue.sv
// eth_rx_frame_queue: receive-side Ethernet frame buffer with an APB read-out port.
// Frames arrive as 32-bit beats, are staged in a circular word buffer and become
// visible only on a good commit. Software reads the head frame word by word,
// then pops it.
// Ports:
//   pclk, preset_n                 clock, async active-low reset
//   psel/penable/pwrite/paddr/pwdata  APB request
//   pready/prdata/pslverr          APB completion (one wait state)
//   rx_start/rx_data_valid/rx_data/rx_bytes_valid/rx_commit/rx_drop  frame input
//   link_up                        low flushes the queue (drop counter kept)
//   rx_frame_ready                 registered "one or more frames queued"
module eth_rx_frame_queue #(
    parameter int unsigned DEPTH         = 4096,
    parameter int unsigned HDR_DEPTH     = 32,
    parameter int unsigned MAX_FRAME_LEN = 1518
) (
    input  logic        pclk,
    input  logic        preset_n,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [11:0] paddr,
    input  logic [31:0] pwdata,
    output logic        pready,
    output logic [31:0] prdata,
    output logic        pslverr,
    input  logic        rx_start,
    input  logic        rx_data_valid,
    input  logic [31:0] rx_data,
    input  logic [2:0]  rx_bytes_valid,
    input  logic        rx_commit,
    input  logic        rx_drop,
    input  logic        link_up,
    output logic        rx_frame_ready
);

    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned PW     = AW + 1;
    localparam int unsigned HW     = $clog2(HDR_DEPTH);
    localparam int unsigned QW     = HW + 1;
    localparam int unsigned LW     = 12;
    localparam int unsigned THRESH = (MAX_FRAME_LEN + 3) / 4 + 1;

    localparam logic [11:0] A_BUF_END = 12'hC00;
    localparam logic [11:0] A_POP     = 12'hFC0;
    localparam logic [11:0] A_LEN     = 12'hFE0;
    localparam logic [11:0] A_PEND    = 12'hFE4;
    localparam logic [11:0] A_DROPS   = 12'hFE8;
    localparam logic [11:0] A_FREE    = 12'hFEC;

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_DROP} state_t;

    state_t          r_state;
    logic [PW-1:0]   r_wr;
    logic [PW-1:0]   r_rd;
    logic [PW-1:0]   r_cur;
    logic [LW-1:0]   r_len;
    logic [QW-1:0]   r_hq_wr;
    logic [QW-1:0]   r_hq_rd;
    logic [LW-1:0]   r_hq [HDR_DEPTH];
    logic [31:0]     r_mem [DEPTH];
    logic [31:0]     r_drops;
    logic            r_pready;
    logic [31:0]     r_prdata;
    logic            r_pslverr;
    logic            r_frame_ready;

    logic [QW-1:0]   w_pending;
    logic            w_hq_full;
    logic [PW-1:0]   w_free;
    logic [LW-1:0]   w_head_len;
    logic [LW-1:0]   w_head_words;
    logic            w_access;
    logic            w_is_buf;
    logic [9:0]      w_idx;
    logic            w_buf_hit;
    logic [AW-1:0]   w_raddr;
    logic            w_pop;
    logic            w_drops_clr;
    logic [31:0]     w_rsp_data;
    logic            w_rsp_err;
    logic [31:0]     w_wdata;
    logic [LW:0]     w_len_add;
    logic [PW-1:0]   w_cur_inc;
    logic            w_wrap_full;
    logic            w_beat;
    logic            w_beat_bad;
    logic            w_recv;
    logic            w_to_drop;
    logic            w_wr_en;
    logic [LW-1:0]   w_len_nx;
    logic [PW-1:0]   w_cur_nx;
    logic            w_commit;
    logic            w_start_drop;
    logic            w_drop_entry;
    logic            w_unused;

    assign w_unused = ^pwdata;

    // Occupancy and head-frame bookkeeping
    assign w_pending    = r_hq_wr - r_hq_rd;
    assign w_hq_full    = (w_pending == QW'(HDR_DEPTH));
    assign w_free       = PW'(DEPTH - 1) - (r_wr - r_rd);
    assign w_head_len   = (w_pending != '0) ? r_hq[r_hq_rd[HW-1:0]] : '0;
    assign w_head_words = (w_head_len + LW'(3)) >> 2;

    // APB decode; a new access is taken only when no completion is in flight
    assign w_access    = psel && penable && !r_pready;
    assign w_is_buf    = (paddr < A_BUF_END) && (paddr[1:0] == 2'b00);
    assign w_idx       = paddr[11:2];
    assign w_buf_hit   = (w_pending != '0) && (LW'(w_idx) < w_head_words);
    assign w_raddr     = r_rd[AW-1:0] + AW'(w_idx);
    assign w_pop       = w_access && pwrite && (paddr == A_POP) && (w_pending != '0);
    assign w_drops_clr = w_access && pwrite && (paddr == A_DROPS);

    // Response data/error for the current access
    always_comb begin
        w_rsp_data = '0;
        w_rsp_err  = 1'b0;
        if (pwrite) begin
            if (paddr == A_POP)
                w_rsp_err = (w_pending == '0);
            else if (paddr != A_DROPS)
                w_rsp_err = 1'b1;
        end else if (w_is_buf) begin
            w_rsp_data = w_buf_hit ? r_mem[w_raddr] : '0;
        end else begin
            case (paddr)
                A_LEN:   w_rsp_data = 32'(w_head_len);
                A_PEND:  w_rsp_data = 32'(w_pending);
                A_DROPS: w_rsp_data = r_drops;
                A_FREE:  w_rsp_data = 32'(w_free);
                default: w_rsp_err  = 1'b1;
            endcase
        end
    end

    // Store bytes little-endian so reads need no swap; bytes past the valid count read as 0
    assign w_wdata = {(rx_bytes_valid >= 3'd4) ? rx_data[7:0]   : 8'h00,
                      (rx_bytes_valid >= 3'd3) ? rx_data[15:8]  : 8'h00,
                      (rx_bytes_valid >= 3'd2) ? rx_data[23:16] : 8'h00,
                      rx_data[31:24]};

    // Push-side next values; rx_start overrides anything else in the same cycle
    assign w_recv       = link_up && !rx_start && (r_state == S_RECV);
    assign w_len_add    = {1'b0, r_len} + (LW + 1)'(rx_bytes_valid);
    assign w_cur_inc    = r_cur + PW'(1);
    assign w_wrap_full  = ((w_cur_inc - r_rd) >= PW'(DEPTH));
    assign w_beat       = w_recv && rx_data_valid;
    assign w_beat_bad   = w_beat && ((w_len_add > (LW + 1)'(MAX_FRAME_LEN)) || w_wrap_full);
    assign w_to_drop    = w_recv && (rx_drop || w_beat_bad);
    assign w_wr_en      = w_beat && !w_to_drop;
    assign w_len_nx     = w_wr_en ? w_len_add[LW-1:0] : r_len;
    assign w_cur_nx     = w_wr_en ? w_cur_inc : r_cur;
    assign w_commit     = w_recv && !w_to_drop && rx_commit && (w_len_nx != '0);
    assign w_start_drop = (w_free < PW'(THRESH)) || w_hq_full;
    assign w_drop_entry = link_up && ((rx_start && w_start_drop) || w_to_drop);

    // Buffer and header storage (no reset needed)
    always_ff @(posedge pclk) begin
        if (w_wr_en)
            r_mem[r_cur[AW-1:0]] <= w_wdata;
        if (w_commit)
            r_hq[r_hq_wr[HW-1:0]] <= w_len_nx;
    end

    // APB completion, counters, pointers and push FSM
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_pready      <= 1'b0;
            r_prdata      <= '0;
            r_pslverr     <= 1'b0;
            r_frame_ready <= 1'b0;
            r_drops       <= '0;
            r_state       <= S_IDLE;
            r_wr          <= '0;
            r_rd          <= '0;
            r_cur         <= '0;
            r_len         <= '0;
            r_hq_wr       <= '0;
            r_hq_rd       <= '0;
        end else begin
            r_pready      <= w_access;
            r_prdata      <= w_access ? w_rsp_data : '0;
            r_pslverr     <= w_access && w_rsp_err;
            r_frame_ready <= (w_pending != '0);

            // Clear wins over a coinciding drop
            if (w_drops_clr)
                r_drops <= '0;
            else if (w_drop_entry && (r_drops != '1))
                r_drops <= r_drops + 32'd1;

            if (!link_up) begin
                r_state <= S_IDLE;
                r_wr    <= '0;
                r_rd    <= '0;
                r_cur   <= '0;
                r_len   <= '0;
                r_hq_wr <= '0;
                r_hq_rd <= '0;
            end else begin
                if (w_pop) begin
                    r_rd    <= r_rd + PW'(w_head_words);
                    r_hq_rd <= r_hq_rd + QW'(1);
                end
                if (w_commit) begin
                    r_hq_wr <= r_hq_wr + QW'(1);
                    r_wr    <= w_cur_nx;
                end
                if (rx_start) begin
                    r_state <= w_start_drop ? S_DROP : S_RECV;
                    r_cur   <= r_wr;
                    r_len   <= '0;
                end else begin
                    case (r_state)
                        S_RECV: begin
                            if (w_to_drop) begin
                                r_state <= S_DROP;
                                r_cur   <= r_wr;
                                r_len   <= '0;
                            end else if (rx_commit) begin
                                r_state <= S_IDLE;
                            end else begin
                                r_cur <= w_cur_nx;
                                r_len <= w_len_nx;
                            end
                        end
                        default: r_state <= r_state;
                    endcase
                end
            end
        end
    end

    assign pready         = r_pready;
    assign prdata         = r_prdata;
    assign pslverr        = r_pslverr;
    assign rx_frame_ready = r_frame_ready;

endmodule

// File: tb/tb_eth_rx_frame_queue.sv
// Bench for eth_rx_frame_queue: random frames against a byte-queue model of the
// committed frames, their lengths and the drop counter.
module tb_eth_rx_frame_queue;

    localparam int unsigned DEPTH  = 1024;
    localparam int unsigned HDR    = 32;
    localparam int unsigned MAXL   = 1518;
    localparam int unsigned THRESH = (MAXL + 3) / 4 + 1;

    localparam logic [11:0] A_POP   = 12'hFC0;
    localparam logic [11:0] A_LEN   = 12'hFE0;
    localparam logic [11:0] A_PEND  = 12'hFE4;
    localparam logic [11:0] A_DROPS = 12'hFE8;
    localparam logic [11:0] A_FREE  = 12'hFEC;

    logic        pclk, preset_n, psel, penable, pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata, prdata;
    logic        pready, pslverr;
    logic        rx_start, rx_data_valid, rx_commit, rx_drop, link_up, rx_frame_ready;
    logic [31:0] rx_data;
    logic [2:0]  rx_bytes_valid;

    eth_rx_frame_queue #(.DEPTH(DEPTH), .HDR_DEPTH(HDR), .MAX_FRAME_LEN(MAXL)) dut (
        .pclk(pclk), .preset_n(preset_n),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .pready(pready), .prdata(prdata), .pslverr(pslverr),
        .rx_start(rx_start), .rx_data_valid(rx_data_valid), .rx_data(rx_data),
        .rx_bytes_valid(rx_bytes_valid), .rx_commit(rx_commit), .rx_drop(rx_drop),
        .link_up(link_up), .rx_frame_ready(rx_frame_ready)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: committed bytes in arrival order, per-frame lengths, drops
    logic [7:0] m_bytes[$];
    int         m_lens[$];
    int         m_drops = 0;

    logic [31:0] rd_d;
    logic        rd_e;
    bit          rd_idle;

    function automatic int m_free();
        int s = 0;
        foreach (m_lens[i]) s += (m_lens[i] + 3) / 4;
        return int'(DEPTH) - 1 - s;
    endfunction

    function automatic logic [31:0] m_word(input int n);
        logic [31:0] w = '0;
        if (m_lens.size() == 0) return '0;
        for (int k = 0; k < 4; k++)
            if (4 * n + k < m_lens[0]) w[8 * k +: 8] = m_bytes[4 * n + k];
        return w;
    endfunction

    task automatic m_pop();
        repeat (m_lens[0]) void'(m_bytes.pop_front());
        void'(m_lens.pop_front());
    endtask

    // One APB transfer; rd_idle reports that the completion was a single-cycle pulse
    task automatic apb(input bit wr, input logic [11:0] addr, input logic [31:0] wdata);
        bit got = 0;
        rd_d = 32'hDEAD_BEEF;
        rd_e = 1'bx;
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        @(posedge pclk); #1;
        penable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge pclk); #1;
            if (pready) begin
                rd_d = prdata;
                rd_e = pslverr;
                got  = 1;
                break;
            end
        end
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        rd_idle = (pready === 1'b0) && (prdata === '0) && (pslverr === 1'b0);
        if (!got) begin
            n_checks++;
            n_errors++;
            $display("FAIL apb_timeout: addr %h got no pready, want pready within 8 cycles", addr);
        end
    endtask

    // Drive one frame and update the model from the acceptance rules
    task automatic send_frame(input int len, input bit incr, input bit do_commit, input bit do_abort);
        logic [7:0]  fb[$];
        logic [31:0] d;
        int          nb;
        bit          acc = (m_free() >= int'(THRESH)) && (m_lens.size() < HDR);
        for (int i = 0; i < len; i++) fb.push_back(incr ? 8'(i) : 8'($urandom));
        @(posedge pclk); #1;
        rx_start = 1'b1;
        @(posedge pclk); #1;
        rx_start = 1'b0;
        for (int i = 0; i < len; i += 4) begin
            nb = (len - i > 4) ? 4 : len - i;
            d  = '0;
            for (int k = 0; k < nb; k++) d[31 - 8 * k -: 8] = fb[i + k];
            rx_data_valid = 1'b1; rx_data = d; rx_bytes_valid = 3'(nb);
            @(posedge pclk); #1;
        end
        rx_data_valid = 1'b0; rx_data = '0; rx_bytes_valid = 3'd0;
        if (do_abort) rx_drop = 1'b1;
        else if (do_commit) rx_commit = 1'b1;
        @(posedge pclk); #1;
        rx_drop = 1'b0; rx_commit = 1'b0;
        if (!acc || len > int'(MAXL) || do_abort) m_drops++;
        else if (do_commit && len > 0) begin
            m_lens.push_back(len);
            foreach (fb[i]) m_bytes.push_back(fb[i]);
        end
    endtask

    // Read the head frame (plus one word past its end), pop it, confirm the count
    task automatic pop_and_verify(input string name);
        int l = m_lens[0];
        apb(0, A_LEN, '0);
        n_checks++;
        if (rd_d !== 32'(l) || rd_e !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_len: got %0d err %b, want %0d", name, rd_d, rd_e, l);
        end
        for (int n = 0; n <= (l + 3) / 4; n++) begin
            apb(0, 12'(4 * n), '0);
            n_checks++;
            if (rd_d !== m_word(n) || rd_e !== 1'b0) begin
                n_errors++;
                $display("FAIL %s_word%0d: got %h err %b, want %h", name, n, rd_d, rd_e, m_word(n));
            end
        end
        apb(1, A_POP, '0);
        m_pop();
        apb(0, A_PEND, '0);
        n_checks++;
        if (rd_d !== 32'(m_lens.size())) begin
            n_errors++;
            $display("FAIL %s_pending_after_pop: got %0d, want %0d", name, rd_d, m_lens.size());
        end
    endtask

    task automatic test_reset();
        preset_n = 1'b0; link_up = 1'b1;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = A_FREE; pwdata = '0;
        rx_start = 1'b0; rx_data_valid = 1'b0; rx_data = '0; rx_bytes_valid = 3'd0;
        rx_commit = 1'b0; rx_drop = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        n_checks++;
        if (pready !== 1'b0 || prdata !== '0 || pslverr !== 1'b0 || rx_frame_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_outputs: got pready %b prdata %h pslverr %b ready %b, want all 0",
                     pready, prdata, pslverr, rx_frame_ready);
        end
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        preset_n = 1'b1;
        apb(0, A_FREE, '0);
        n_checks++;
        if (rd_d !== 32'(DEPTH - 1)) begin
            n_errors++;
            $display("FAIL reset_free: got %0d, want %0d", rd_d, DEPTH - 1);
        end
        apb(0, A_PEND, '0);
        n_checks++;
        if (rd_d !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_pending: got %0d, want 0", rd_d);
        end
        apb(0, A_DROPS, '0);
        n_checks++;
        if (rd_d !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_drops: got %0d, want 0", rd_d);
        end
    endtask

    task automatic test_basic();
        send_frame(64, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (rx_frame_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_ready_early: got %b one cycle after commit, want 0", rx_frame_ready);
        end
        @(posedge pclk); #1;
        n_checks++;
        if (rx_frame_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL basic_ready: got %b two cycles after commit, want 1", rx_frame_ready);
        end
        apb(0, 12'h000, '0);
        n_checks++;
        if (rd_d !== 32'h0302_0100 || rd_e !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_word0: got %h err %b, want 03020100", rd_d, rd_e);
        end
        n_checks++;
        if (!rd_idle) begin
            n_errors++;
            $display("FAIL basic_pready_pulse: got pready %b prdata %h after completion, want 0/0", pready, prdata);
        end
        apb(0, 12'h100, '0);
        n_checks++;
        if (rd_d !== 32'd0 || rd_e !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_word64: got %h err %b, want 0", rd_d, rd_e);
        end
        apb(0, A_PEND, '0);
        n_checks++;
        if (rd_d !== 32'd1) begin
            n_errors++;
            $display("FAIL basic_pending: got %0d, want 1", rd_d);
        end
        pop_and_verify("basic");
    endtask

    task automatic test_multi();
        int lens[3] = '{61, 64, 1};
        foreach (lens[i]) send_frame(lens[i], 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (m_lens[0] != lens[i]) begin
                n_errors++;
                $display("FAIL multi_order: model head %0d, want %0d", m_lens[0], lens[i]);
            end
            pop_and_verify("multi");
        end
        apb(0, A_FREE, '0);
        n_checks++;
        if (rd_d !== 32'(DEPTH - 1)) begin
            n_errors++;
            $display("FAIL multi_free: got %0d, want %0d", rd_d, DEPTH - 1);
        end
        apb(1, A_POP, '0);
        n_checks++;
        if (rd_e !== 1'b1) begin
            n_errors++;
            $display("FAIL multi_empty_pop: got pslverr %b, want 1", rd_e);
        end
    endtask

    task automatic test_errors();
        logic [12:0] tbl[5] = '{{1'b0, A_POP}, {1'b1, A_LEN}, {1'b1, A_FREE},
                                {1'b0, 12'hC00}, {1'b0, 12'hFF0}};
        foreach (tbl[i]) begin
            apb(tbl[i][12], tbl[i][11:0], 32'h1234_5678);
            n_checks++;
            if (rd_e !== 1'b1 || rd_d !== 32'd0) begin
                n_errors++;
                $display("FAIL err_access%0d: addr %h got err %b data %h, want err 1 data 0",
                         i, tbl[i][11:0], rd_e, rd_d);
            end
        end
    endtask

    task automatic test_oversize();
        int f = m_free();
        send_frame(1600, 1'b0, 1'b1, 1'b0);
        apb(0, A_DROPS, '0);
        n_checks++;
        if (rd_d !== 32'(m_drops) || rd_d !== 32'd1) begin
            n_errors++;
            $display("FAIL oversize_drops: got %0d, want %0d", rd_d, m_drops);
        end
        apb(0, A_FREE, '0);
        n_checks++;
        if (rd_d !== 32'(f)) begin
            n_errors++;
            $display("FAIL oversize_free: got %0d, want %0d", rd_d, f);
        end
        send_frame(80, 1'b0, 1'b1, 1'b1);
        send_frame(0, 1'b0, 1'b1, 1'b0);
        apb(0, A_DROPS, '0);
        n_checks++;
        if (rd_d !== 32'(m_drops)) begin
            n_errors++;
            $display("FAIL abort_drops: got %0d, want %0d", rd_d, m_drops);
        end
        apb(0, A_PEND, '0);
        n_checks++;
        if (rd_d !== 32'd0) begin
            n_errors++;
            $display("FAIL oversize_pending: got %0d, want 0", rd_d);
        end
        send_frame(100, 1'b0, 1'b1, 1'b0);
        pop_and_verify("after_oversize");
    endtask

    task automatic test_full();
        send_frame(int'(MAXL), 1'b0, 1'b1, 1'b0);
        send_frame(int'(MAXL), 1'b0, 1'b1, 1'b0);
        send_frame(200, 1'b0, 1'b1, 1'b0);
        apb(0, A_DROPS, '0);
        n_checks++;
        if (rd_d !== 32'(m_drops)) begin
            n_errors++;
            $display("FAIL full_drops: got %0d, want %0d", rd_d, m_drops);
        end
        apb(0, A_PEND, '0);
        n_checks++;
        if (rd_d !== 32'd2) begin
            n_errors++;
            $display("FAIL full_pending: got %0d, want 2", rd_d);
        end
        pop_and_verify("full_head");
        send_frame(300, 1'b0, 1'b1, 1'b0);
        pop_and_verify("full_second");
        pop_and_verify("full_after_pop");
    endtask

    task automatic test_wrap();
        for (int it = 0; it < 12; it++) begin
            send_frame(int'($urandom_range(1, MAXL)), 1'b0, 1'b1, 1'b0);
            if (m_lens.size() != 0) pop_and_verify("wrap");
        end
        apb(0, A_FREE, '0);
        n_checks++;
        if (rd_d !== 32'(m_free())) begin
            n_errors++;
            $display("FAIL wrap_free: got %0d, want %0d", rd_d, m_free());
        end
    endtask

    task automatic test_link();
        send_frame(100, 1'b0, 1'b1, 1'b0);
        send_frame(50, 1'b0, 1'b1, 1'b0);
        @(posedge pclk); #1;
        rx_start = 1'b1;
        @(posedge pclk); #1;
        rx_start = 1'b0; rx_data_valid = 1'b1; rx_data = $urandom; rx_bytes_valid = 3'd4;
        repeat (3) @(posedge pclk);
        #1;
        link_up = 1'b0;
        m_bytes.delete();
        m_lens.delete();
        repeat (3) @(posedge pclk);
        #1;
        rx_data_valid = 1'b0;
        apb(0, A_PEND, '0);
        n_checks++;
        if (rd_d !== 32'd0 || rx_frame_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL link_flush: got pending %0d ready %b, want 0/0", rd_d, rx_frame_ready);
        end
        apb(0, A_DROPS, '0);
        n_checks++;
        if (rd_d !== 32'(m_drops)) begin
            n_errors++;
            $display("FAIL link_drops_kept: got %0d, want %0d", rd_d, m_drops);
        end
        apb(1, A_DROPS, 32'hFFFF_FFFF);
        m_drops = 0;
        apb(0, A_DROPS, '0);
        n_checks++;
        if (rd_d !== 32'd0) begin
            n_errors++;
            $display("FAIL link_drops_clear: got %0d, want 0", rd_d);
        end
        link_up = 1'b1;
        send_frame(40, 1'b0, 1'b1, 1'b0);
        pop_and_verify("after_link");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_multi();
        test_errors();
        test_oversize();
        test_full();
        test_wrap();
        test_link();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at 2 ms, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
